// File: rtl/data_store_buffer.sv
// data_store_buffer: posted-write store FIFO in front of a 1R1W RAM, with load forwarding of pending bytes; optional STORE_BUF_COALESCE_EN merges same-word stores into the youngest entry
module data_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                core_rd_addr,
  output logic [31:0]                core_rd_data,
  input  logic [1:0]                 core_wr,
  input  logic [31:0]                core_wr_addr,
  input  logic [31:0]                core_wr_data,
  output logic [31:0]                mem_rd_addr,
  input  logic [31:0]                mem_rd_data,
  output logic                       mem_wr_valid,
  input  logic                       mem_wr_ready,
  output logic [31:0]                mem_wr_addr,
  output logic [3:0]                 mem_wr_strb,
  output logic [31:0]                mem_wr_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [29:0] e_addr [DEPTH];
  logic [3:0]  e_strb [DEPTH];
  logic [31:0] e_data [DEPTH];
  logic [AW-1:0] rptr, wptr, ypos, idx;
  logic [CW-1:0] cnt;
  logic [1:0] base;
  logic [3:0] n_strb, hit_d, hit_q;
  logic [31:0] n_mask, n_data, fwd_d, fwd_q;
  logic push, pop, accept, coalesce;
  assign base = core_wr == 2'b01 ? core_wr_addr[1:0] : core_wr == 2'b10 ? {core_wr_addr[1], 1'b0} : 2'b00;
  assign n_strb = (core_wr == 2'b01 ? 4'b0001 : core_wr == 2'b10 ? 4'b0011 : core_wr == 2'b11 ? 4'b1111 : 4'b0000) << base;
  assign n_mask = {{8{n_strb[3]}}, {8{n_strb[2]}}, {8{n_strb[1]}}, {8{n_strb[0]}}};
  assign n_data = (core_wr_data << {base, 3'b000}) & n_mask;
  assign push = core_wr != 2'b00;
  assign pop = mem_wr_valid && mem_wr_ready;
  assign ypos = wptr - 1'b1;
`ifdef STORE_BUF_COALESCE_EN
  // with a single entry that is leaving this cycle there is nothing left to merge into
  assign coalesce = push && cnt != '0 && e_addr[ypos] == core_wr_addr[31:2] && (cnt >= CW'(2) || !pop);
`else
  assign coalesce = 1'b0;
`endif
  assign accept = push && !coalesce && (cnt < CW'(DEPTH) || pop);
  assign count = cnt;
  // gated by rst_n so no RAM write escapes during the reset cycle
  assign mem_wr_valid = rst_n && cnt != '0;
  assign mem_wr_addr = mem_wr_valid ? {e_addr[rptr], 2'b00} : '0;
  assign mem_wr_strb = mem_wr_valid ? e_strb[rptr] : '0;
  assign mem_wr_data = mem_wr_valid ? e_data[rptr] : '0;
  assign mem_rd_addr = core_rd_addr;
  // oldest to youngest, then the incoming push, so later writers win per lane;
  // the head is searched even while popping because the RAM returns old data
  always_comb begin
    hit_d = '0;
    fwd_d = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + AW'(i);
      if (CW'(i) < cnt && e_addr[idx] == core_rd_addr[31:2])
        for (int l = 0; l < 4; l++)
          if (e_strb[idx][l]) begin
            hit_d[l] = 1'b1;
            fwd_d[8*l +: 8] = e_data[idx][8*l +: 8];
          end
    end
    if ((accept || coalesce) && core_wr_addr[31:2] == core_rd_addr[31:2])
      for (int l = 0; l < 4; l++)
        if (n_strb[l]) begin
          hit_d[l] = 1'b1;
          fwd_d[8*l +: 8] = n_data[8*l +: 8];
        end
  end
  always_comb begin
    core_rd_data = mem_rd_data;
    for (int l = 0; l < 4; l++)
      core_rd_data[8*l +: 8] = hit_q[l] ? fwd_q[8*l +: 8] : mem_rd_data[8*l +: 8];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr <= '0;
      wptr <= '0;
      cnt <= '0;
      overflow <= 1'b0;
      hit_q <= '0;
      fwd_q <= '0;
    end else begin
      rptr <= rptr + AW'(pop);
      wptr <= wptr + AW'(accept);
      cnt <= cnt + CW'(accept) - CW'(pop);
      if (push && !accept && !coalesce) overflow <= 1'b1;
      hit_q <= hit_d;
      fwd_q <= fwd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      e_addr[wptr] <= core_wr_addr[31:2];
      e_strb[wptr] <= n_strb;
      e_data[wptr] <= n_data;
    end
    if (rst_n && coalesce) begin
      e_strb[ypos] <= e_strb[ypos] | n_strb;
      e_data[ypos] <= (e_data[ypos] & ~n_mask) | n_data;
    end
  end
endmodule

// File: tb/tb_data_store_buffer.sv
// tb_data_store_buffer: scoreboard bench for data_store_buffer (RAM writes and load data checked by a monitor)
module tb_data_store_buffer;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 0;
  logic [31:0] core_rd_addr = 0, core_rd_data, core_wr_addr = 0, core_wr_data = 0;
  logic [1:0] core_wr = 0;
  logic [31:0] mem_rd_addr, mem_rd_data = 0, mem_wr_addr, mem_wr_data;
  logic mem_wr_valid, mem_wr_ready = 0, overflow;
  logic [3:0] mem_wr_strb;
  logic [$clog2(DEPTH):0] count;
  logic ld = 0, ld_tag = 0;
  logic [31:0] ram_next = 0;
  logic [67:0] exp_wr [$];
  logic [31:0] exp_rd [$];
  int total = 0, bad = 0;
  data_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .core_rd_addr(core_rd_addr), .core_rd_data(core_rd_data),
    .core_wr(core_wr), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_wr_valid(mem_wr_valid),
    .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr), .mem_wr_strb(mem_wr_strb),
    .mem_wr_data(mem_wr_data), .count(count), .overflow(overflow));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    ld_tag <= ld;
    mem_rd_data <= ram_next;
  end
  always @(negedge clk) begin
    if (mem_wr_valid && mem_wr_ready) begin
      total++;
      if (exp_wr.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected got=%h/%b/%h expected=none", mem_wr_addr, mem_wr_strb, mem_wr_data);
      end else begin
        automatic logic [67:0] e = exp_wr.pop_front();
        if ({mem_wr_addr, mem_wr_strb, mem_wr_data} !== e) begin
          bad++;
          $display("FAIL wr_entry got=%h/%b/%h expected=%h/%b/%h", mem_wr_addr, mem_wr_strb, mem_wr_data, e[67:36], e[35:32], e[31:0]);
        end
      end
    end
    if (ld_tag) begin
      total++;
      if (exp_rd.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected got=%h expected=none", core_rd_data);
      end else begin
        automatic logic [31:0] e = exp_rd.pop_front();
        if (core_rd_data !== e) begin
          bad++;
          $display("FAIL rd_data addr_word got=%h expected=%h", core_rd_data, e);
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    core_wr = 0;
    ld = 0;
  endtask
  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    core_wr = sz;
    core_wr_addr = a;
    core_wr_data = d;
  endtask
  task automatic ldr(input logic [31:0] a, input logic [31:0] ram, input logic [31:0] e);
    core_rd_addr = a;
    ram_next = ram;
    ld = 1;
    exp_rd.push_back(e);
  endtask
  task automatic drain();
    mem_wr_ready = 1;
    for (int k = 0; k < 20 && exp_wr.size() != 0; k++) tick();
    tick();
    chk("drain_done", 32'(exp_wr.size()), 0);
    chk("drain_count", 32'(count), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    ram_next = 32'h12345678;
    tick();
    tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(mem_wr_valid), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_wr_addr", mem_wr_addr, 0);
    chk("rst_wr_strb", 32'(mem_wr_strb), 0);
    chk("rst_wr_data", mem_wr_data, 0);
    chk("rst_rd_data", core_rd_data, 32'h12345678);
    rst_n = 1;
    mem_wr_ready = 1;
    st(2'b11, 32'h100, 32'hDEADBEEF);
    exp_wr.push_back({32'h100, 4'b1111, 32'hDEADBEEF});
    chk("latency_not_before", 32'(mem_wr_valid), 0);
    tick();
    chk("word_valid", 32'(mem_wr_valid), 1);
    tick();
    chk("word_count_after", 32'(count), 0);
    mem_wr_ready = 0;
    st(2'b01, 32'h203, 32'h000000AB);
    exp_wr.push_back({32'h200, 4'b1000, 32'hAB000000});
    tick();
    ldr(32'h200, 32'h11223344, 32'hAB223344);
    tick();
    mem_wr_ready = 1;
    tick();
    tick();
    chk("byte_drained", 32'(count), 0);
    st(2'b01, 32'h10, 32'h00000055);
    exp_wr.push_back({32'h10, 4'b0001, 32'h00000055});
    tick();
    ldr(32'h10, 32'h0, 32'h00000055);
    tick();
    st(2'b11, 32'h20, 32'hCAFEF00D);
    exp_wr.push_back({32'h20, 4'b1111, 32'hCAFEF00D});
    ldr(32'h20, 32'h0, 32'hCAFEF00D);
    tick();
    ldr(32'h300, 32'h0BADCAFE, 32'h0BADCAFE);
    tick();
    tick();
    mem_wr_ready = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      st(2'b11, 32'h400 + 32'(4 * i), 32'h1000 + 32'(i));
      if (i < DEPTH) exp_wr.push_back({32'h400 + 32'(4 * i), 4'b1111, 32'h1000 + 32'(i)});
      tick();
    end
    chk("full_count", 32'(count), DEPTH);
    chk("full_overflow", 32'(overflow), 1);
    ldr(32'h410, 32'h77777777, 32'h77777777);
    tick();
    ldr(32'h40C, 32'h0, 32'h00001003);
    tick();
    drain();
    chk("overflow_sticky", 32'(overflow), 1);
    mem_wr_ready = 0;
    st(2'b11, 32'h700, 32'h1);
    tick();
    st(2'b11, 32'h704, 32'h2);
    tick();
    rst_n = 0;
    mem_wr_ready = 1;
    #1;
    chk("rst_cycle_no_write", 32'(mem_wr_valid), 0);
    tick();
    rst_n = 1;
    chk("rst_mid_count", 32'(count), 0);
    chk("rst_mid_overflow", 32'(overflow), 0);
    mem_wr_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      st(2'b11, 32'h500 + 32'(4 * i), 32'h2000 + 32'(i));
      exp_wr.push_back({32'h500 + 32'(4 * i), 4'b1111, 32'h2000 + 32'(i)});
      tick();
    end
    mem_wr_ready = 1;
    st(2'b11, 32'h600, 32'h3000);
    exp_wr.push_back({32'h600, 4'b1111, 32'h3000});
    tick();
    mem_wr_ready = 0;
    chk("pushpop_count", 32'(count), DEPTH);
    chk("pushpop_overflow", 32'(overflow), 0);
    drain();
    mem_wr_ready = 0;
    st(2'b10, 32'h40, 32'h00001234);
    tick();
    st(2'b01, 32'h43, 32'h00000099);
    tick();
`ifdef STORE_BUF_COALESCE_EN
    exp_wr.push_back({32'h40, 4'b1011, 32'h99001234});
    chk("coalesce_count", 32'(count), 1);
`else
    exp_wr.push_back({32'h40, 4'b0011, 32'h00001234});
    exp_wr.push_back({32'h40, 4'b1000, 32'h99000000});
    chk("coalesce_count", 32'(count), 2);
`endif
    ldr(32'h40, 32'hAABBCCDD, 32'h99BB1234);
    tick();
    drain();
    tick();
    chk("rd_queue_empty", 32'(exp_rd.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
